// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register_file write port between NREQ requesters
// using a req/gnt handshake, and runs a clear sweep that writes zero to every
// register. All outputs are registered.
// Build option: RF_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins)
// instead of the default round-robin arbitration.
module rf_write_arbiter #(
    parameter int NREQ = 2,
    parameter int N    = 4,
    parameter int W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*N-1:0] addr_i,
    input  logic [NREQ*W-1:0] data_i,
    output logic [NREQ-1:0]   gnt,
    output logic              rf_we,
    output logic [N-1:0]      rf_addr,
    output logic [W-1:0]      rf_data,
    output logic              busy
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [N-1:0]    ADDR_LAST = {N{1'b1}};
    localparam logic [NREQ-1:0] GNT_ONE   = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t           state_r;
    logic [N-1:0]     cur_addr_r;
    logic [NREQ-1:0]  eligible_s;
    logic [PTR_W-1:0] winner_s;
    logic             found_s;

    // A requester whose grant is showing this cycle already had its write;
    // masking it prevents a second write from the same request sample.
    assign eligible_s = req & ~gnt;

`ifdef RF_ARB_FIXED_PRIO_EN

    // Fixed priority: scan from the top down so the lowest eligible index is the last one kept.
    always_comb begin
        found_s  = 1'b0;
        winner_s = {PTR_W{1'b0}};
        for (int i = NREQ - 1; i >= 0; i--) begin
            winner_s = eligible_s[i] ? PTR_W'(i) : winner_s;
            found_s  = found_s | eligible_s[i];
        end
    end

`else

    logic [PTR_W-1:0] ptr_r;
    logic [PTR_W-1:0] idx_s;

    // Round-robin: scan offsets NREQ..1 past the pointer so the nearest one after the pointer is kept.
    always_comb begin
        found_s  = 1'b0;
        winner_s = {PTR_W{1'b0}};
        idx_s    = {PTR_W{1'b0}};
        for (int i = NREQ; i >= 1; i--) begin
            idx_s    = PTR_W'((int'(ptr_r) + i) % NREQ);
            winner_s = eligible_s[idx_s] ? idx_s : winner_s;
            found_s  = found_s | eligible_s[idx_s];
        end
    end

`endif

    // Control FSM: arbitration in IDLE, zero sweep in CLEAR; drives all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cur_addr_r <= {N{1'b0}};
            gnt        <= {NREQ{1'b0}};
            rf_we      <= 1'b0;
            rf_addr    <= {N{1'b0}};
            rf_data    <= {W{1'b0}};
            busy       <= 1'b0;
`ifndef RF_ARB_FIXED_PRIO_EN
            ptr_r      <= PTR_W'(NREQ - 1);
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (clr_req) begin
                        // Clear wins over any pending request; requests wait for the sweep.
                        state_r    <= ST_CLEAR;
                        cur_addr_r <= {N{1'b0}};
                        gnt        <= {NREQ{1'b0}};
                        rf_we      <= 1'b0;
                        busy       <= 1'b1;
                    end else if (found_s) begin
                        gnt     <= GNT_ONE << winner_s;
                        rf_we   <= 1'b1;
                        rf_addr <= addr_i[winner_s*N +: N];
                        rf_data <= data_i[winner_s*W +: W];
                        busy    <= 1'b0;
`ifndef RF_ARB_FIXED_PRIO_EN
                        ptr_r   <= winner_s;
`endif
                    end else begin
                        gnt   <= {NREQ{1'b0}};
                        rf_we <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    // One zero write per cycle; clr_req is ignored so the sweep never restarts.
                    gnt        <= {NREQ{1'b0}};
                    rf_we      <= 1'b1;
                    rf_addr    <= cur_addr_r;
                    rf_data    <= {W{1'b0}};
                    busy       <= 1'b1;
                    cur_addr_r <= cur_addr_r + {{(N-1){1'b0}}, 1'b1};
                    if (cur_addr_r == ADDR_LAST) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_CLEAR;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    gnt     <= {NREQ{1'b0}};
                    rf_we   <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed testbench for rf_write_arbiter (NREQ=2, N=4, W=8).
module tb_rf_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic        clr_req;
    logic [1:0]  req;
    logic [7:0]  addr_i;
    logic [15:0] data_i;
    logic [1:0]  gnt;
    logic        rf_we;
    logic [3:0]  rf_addr;
    logic [7:0]  rf_data;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    rf_write_arbiter #(.NREQ(2), .N(4), .W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_req (clr_req),
        .req     (req),
        .addr_i  (addr_i),
        .data_i  (data_i),
        .gnt     (gnt),
        .rf_we   (rf_we),
        .rf_addr (rf_addr),
        .rf_data (rf_data),
        .busy    (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n   = 1'b0;
        req     = 2'b00;
        clr_req = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        clr_req = 1'($urandom_range(0, 1));
        req     = 2'($urandom_range(0, 3));
        addr_i  = 8'($urandom);
        data_i  = 16'($urandom);
        #3;
        n_checks++; if (gnt !== 2'b00)    begin n_fail++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
        n_checks++; if (rf_we !== 1'b0)   begin n_fail++; $display("FAIL reset_we got=%b exp=0", rf_we); end
        n_checks++; if (rf_addr !== 4'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", rf_addr); end
        n_checks++; if (rf_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", rf_data); end
        n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        do_reset();
    endtask

    task automatic test_single_write;
        req    = 2'b01;
        addr_i = 8'h03;
        data_i = 16'h00A5;
        tick();
        req = 2'b00;
        n_checks++; if (gnt !== 2'b01)     begin n_fail++; $display("FAIL single_gnt got=%b exp=01", gnt); end
        n_checks++; if (rf_we !== 1'b1)    begin n_fail++; $display("FAIL single_we got=%b exp=1", rf_we); end
        n_checks++; if (rf_addr !== 4'h3)  begin n_fail++; $display("FAIL single_addr got=%h exp=3", rf_addr); end
        n_checks++; if (rf_data !== 8'hA5) begin n_fail++; $display("FAIL single_data got=%h exp=a5", rf_data); end
        tick();
        n_checks++; if (rf_we !== 1'b0)    begin n_fail++; $display("FAIL single_we_after got=%b exp=0", rf_we); end
        n_checks++; if (gnt !== 2'b00)     begin n_fail++; $display("FAIL single_gnt_after got=%b exp=00", gnt); end
    endtask

    task automatic test_back_to_back;
        logic [1:0] exp_gnt;
        logic [3:0] exp_addr;
        logic [7:0] exp_data;
        do_reset();
        addr_i = {4'h9, 4'h2};
        data_i = {8'h5A, 8'h11};
        req    = 2'b11;
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_gnt  = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_addr = (k % 2 == 0) ? 4'h2 : 4'h9;
            exp_data = (k % 2 == 0) ? 8'h11 : 8'h5A;
            n_checks++; if (gnt !== exp_gnt)      begin n_fail++; $display("FAIL b2b_gnt[%0d] got=%b exp=%b", k, gnt, exp_gnt); end
            n_checks++; if (rf_we !== 1'b1)       begin n_fail++; $display("FAIL b2b_we[%0d] got=%b exp=1", k, rf_we); end
            n_checks++; if (rf_addr !== exp_addr) begin n_fail++; $display("FAIL b2b_addr[%0d] got=%h exp=%h", k, rf_addr, exp_addr); end
            n_checks++; if (rf_data !== exp_data) begin n_fail++; $display("FAIL b2b_data[%0d] got=%h exp=%h", k, rf_data, exp_data); end
            req = 2'b11 & ~exp_gnt;
        end
        req = 2'b00;
        tick();
        n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL b2b_idle_gnt got=%b exp=00", gnt); end
    endtask

    task automatic test_clear_sweep;
        addr_i  = {4'hC, 4'h0};
        data_i  = {8'h77, 8'h00};
        req     = 2'b10;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL clr_start_gnt got=%b exp=00", gnt); end
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL clr_start_we got=%b exp=0", rf_we); end
        n_checks++; if (busy !== 1'b1)  begin n_fail++; $display("FAIL clr_start_busy got=%b exp=1", busy); end
        for (int i = 0; i < 16; i++) begin
            tick();
            clr_req = (i == 8) ? 1'b1 : 1'b0;
            n_checks++; if (rf_we !== 1'b1)       begin n_fail++; $display("FAIL clr_we[%0d] got=%b exp=1", i, rf_we); end
            n_checks++; if (rf_addr !== 4'(i))    begin n_fail++; $display("FAIL clr_addr[%0d] got=%h exp=%h", i, rf_addr, 4'(i)); end
            n_checks++; if (rf_data !== 8'h00)    begin n_fail++; $display("FAIL clr_data[%0d] got=%h exp=00", i, rf_data); end
            n_checks++; if (busy !== 1'b1)        begin n_fail++; $display("FAIL clr_busy[%0d] got=%b exp=1", i, busy); end
            n_checks++; if (gnt !== 2'b00)        begin n_fail++; $display("FAIL clr_gnt[%0d] got=%b exp=00", i, gnt); end
        end
        clr_req = 1'b0;
        tick();
        req = 2'b00;
        n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL clr_end_busy got=%b exp=0", busy); end
        n_checks++; if (gnt !== 2'b10)     begin n_fail++; $display("FAIL clr_end_gnt got=%b exp=10", gnt); end
        n_checks++; if (rf_we !== 1'b1)    begin n_fail++; $display("FAIL clr_end_we got=%b exp=1", rf_we); end
        n_checks++; if (rf_addr !== 4'hC)  begin n_fail++; $display("FAIL clr_end_addr got=%h exp=c", rf_addr); end
        n_checks++; if (rf_data !== 8'h77) begin n_fail++; $display("FAIL clr_end_data got=%h exp=77", rf_data); end
        tick();
        n_checks++; if (rf_we !== 1'b0)    begin n_fail++; $display("FAIL clr_post_we got=%b exp=0", rf_we); end
    endtask

    task automatic test_reset_mid_sweep;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        n_checks++; if (rf_addr !== 4'h5) begin n_fail++; $display("FAIL mid_addr got=%h exp=5", rf_addr); end
        n_checks++; if (busy !== 1'b1)    begin n_fail++; $display("FAIL mid_busy got=%b exp=1", busy); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (rf_we !== 1'b0)    begin n_fail++; $display("FAIL mid_rst_we got=%b exp=0", rf_we); end
        n_checks++; if (rf_addr !== 4'h0)  begin n_fail++; $display("FAIL mid_rst_addr got=%h exp=0", rf_addr); end
        n_checks++; if (rf_data !== 8'h00) begin n_fail++; $display("FAIL mid_rst_data got=%h exp=00", rf_data); end
        n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
        n_checks++; if (gnt !== 2'b00)     begin n_fail++; $display("FAIL mid_rst_gnt got=%b exp=00", gnt); end
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL post_rst_we[%0d] got=%b exp=0", i, rf_we); end
            n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL post_rst_busy[%0d] got=%b exp=0", i, busy); end
        end
    endtask

    task automatic test_priority;
        logic [1:0] exp_both;
        do_reset();
        addr_i = {4'h6, 4'h1};
        data_i = {8'hB2, 8'h3C};
        req    = 2'b01;
        tick();
        req = 2'b00;
        n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL prio_first_gnt got=%b exp=01", gnt); end
        tick();
        req = 2'b11;
        tick();
        req = 2'b00;
`ifdef RF_ARB_FIXED_PRIO_EN
        exp_both = 2'b01;
`else
        exp_both = 2'b10;
`endif
        n_checks++; if (gnt !== exp_both) begin n_fail++; $display("FAIL prio_both_gnt got=%b exp=%b", gnt, exp_both); end
        tick();
        req = 2'b10;
        tick();
        req = 2'b00;
        n_checks++; if (gnt !== 2'b10)     begin n_fail++; $display("FAIL prio_one_gnt got=%b exp=10", gnt); end
        n_checks++; if (rf_data !== 8'hB2) begin n_fail++; $display("FAIL prio_one_data got=%h exp=b2", rf_data); end
        tick();
        n_checks++; if (gnt !== 2'b00)     begin n_fail++; $display("FAIL prio_idle_gnt got=%b exp=00", gnt); end
    endtask

    initial begin
        rst_n   = 1'b0;
        clr_req = 1'b0;
        req     = 2'b00;
        addr_i  = 8'h00;
        data_i  = 16'h0000;
        test_reset();
        test_single_write();
        test_back_to_back();
        test_clear_sweep();
        test_reset_mid_sweep();
        test_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
